demux32_1to2_reg: RTL and testbench

Registered 1-to-2 demultiplexer for 32-bit datapath words: the steering counterpart of the 32-bit 2-to-1 mux, routing one source to one of two destinations instead of selecting one of two sources. Each destination has a one-entry output slot with a valid/ready handshake, so a stalled destination back-pressures only traffic steered to it. Per-destination transfer counters support bring-up and bench checking in the datapath.

---
 rtl/demux32_1to2_reg_pkg.sv | 14 +
 rtl/demux32_1to2_reg_out_slot.sv | 54 +++++
 rtl/demux32_1to2_reg.sv | 64 ++++++
 tb/tb_demux32_1to2_reg.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/demux32_1to2_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux32_1to2_reg_pkg
// Purpose  : Shared constants for the registered 1-to-2 datapath demux.
// Revision : 1.0
// ============================================================================
package demux32_1to2_reg_pkg;
   localparam int   DATA_W     = 32;
   localparam logic SLOT_EMPTY = 1'b0;
   localparam logic SLOT_FULL  = 1'b1;
   localparam logic DEST_A     = 1'b0;
   localparam logic DEST_B     = 1'b1;
endpackage
`default_nettype wire

// File: rtl/demux32_1to2_reg_out_slot.sv
`default_nettype none
// ============================================================================
// Module   : out_slot
// Purpose  : One-entry output slot with valid/ready drain and handshake count.
// Revision : 1.0
// ============================================================================
module out_slot
   import demux32_1to2_reg_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic [CNT_W-1:0] cnt,
   output logic             can_load
);
   logic             r_state;
   logic [WIDTH-1:0] r_data;
   logic [CNT_W-1:0] r_cnt;
   logic             w_drain;

   assign w_drain  = (r_state == SLOT_FULL) && ready;
   // A draining slot can take a new word in the same cycle.
   assign can_load = !Reset && ((r_state == SLOT_EMPTY) || ready);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= SLOT_EMPTY;
         r_data  <= '0;
         r_cnt   <= '0;
      end else begin
         if (load) begin
            r_state <= SLOT_FULL;
            r_data  <= load_data;
         end else if (w_drain) begin
            r_state <= SLOT_EMPTY;
         end
         if (w_drain) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign valid = r_state;
   assign data  = r_data;
   assign cnt   = r_cnt;
endmodule
`default_nettype wire

// File: rtl/demux32_1to2_reg.sv
`default_nettype none
// ============================================================================
// Module   : demux32_1to2_reg
// Purpose  : Registered 1-to-2 demux steering one source into two handshaked slots.
// Revision : 1.0
// ============================================================================
module demux32_1to2_reg
   import demux32_1to2_reg_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] outA_data,
   output logic             outA_valid,
   input  logic             outA_ready,
   output logic [WIDTH-1:0] outB_data,
   output logic             outB_valid,
   input  logic             outB_ready,
   output logic [CNT_W-1:0] cntA,
   output logic [CNT_W-1:0] cntB
);
   logic w_can_a;
   logic w_can_b;
   logic w_accept;
   logic w_load_a;
   logic w_load_b;

   // Only the selected slot gates acceptance, so a stall on one side never blocks the other.
   assign in_ready = (in_sel == DEST_B) ? w_can_b : w_can_a;
   assign w_accept = in_valid && in_ready;
   assign w_load_a = w_accept && (in_sel == DEST_A);
   assign w_load_b = w_accept && (in_sel == DEST_B);

   out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_a (
      .Clk       (Clk),
      .Reset     (Reset),
      .load      (w_load_a),
      .load_data (in_data),
      .ready     (outA_ready),
      .valid     (outA_valid),
      .data      (outA_data),
      .cnt       (cntA),
      .can_load  (w_can_a)
   );

   out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot_b (
      .Clk       (Clk),
      .Reset     (Reset),
      .load      (w_load_b),
      .load_data (in_data),
      .ready     (outB_ready),
      .valid     (outB_valid),
      .data      (outB_data),
      .cnt       (cntB),
      .can_load  (w_can_b)
   );
endmodule
`default_nettype wire

// File: tb/tb_demux32_1to2_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux32_1to2_reg
// Purpose  : Scoreboard bench for demux32_1to2_reg with directed vectors.
// Revision : 1.0
// ============================================================================
module tb_demux32_1to2_reg;
   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] in_data;
   logic        in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] outA_data;
   logic        outA_valid;
   logic        outA_ready;
   logic [31:0] outB_data;
   logic        outB_valid;
   logic        outB_ready;
   logic [7:0]  cntA;
   logic [7:0]  cntB;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] qa[$];
   logic [31:0] qb[$];
   logic [7:0]  na;
   logic [7:0]  nb;

   demux32_1to2_reg #(.WIDTH(32), .CNT_W(8)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .outA_data  (outA_data),
      .outA_valid (outA_valid),
      .outA_ready (outA_ready),
      .outB_data  (outB_data),
      .outB_valid (outB_valid),
      .outB_ready (outB_ready),
      .cntA       (cntA),
      .cntB       (cntB)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Consumer-side monitor: compares whatever each slot presents against the queue head.
   task automatic monitor_loop();
      forever begin
         @(negedge Clk);
         if (Reset) begin
            qa.delete();
            qb.delete();
            na = '0;
            nb = '0;
         end else begin
            chk("cntA_model", {24'd0, cntA}, {24'd0, na});
            chk("cntB_model", {24'd0, cntB}, {24'd0, nb});
            if (outA_valid) begin
               if (qa.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_A: got %h expected no word at %0t", outA_data, $time);
               end else begin
                  chk("outA_data", outA_data, qa[0]);
                  if (outA_ready) void'(qa.pop_front());
               end
               if (outA_ready) na = na + 8'd1;
            end
            if (outB_valid) begin
               if (qb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_B: got %h expected no word at %0t", outB_data, $time);
               end else begin
                  chk("outB_data", outB_data, qb[0]);
                  if (outB_ready) void'(qb.pop_front());
               end
               if (outB_ready) nb = nb + 8'd1;
            end
         end
      end
   endtask

   task automatic offer(input logic sel, input logic [31:0] d, input logic exp_rdy);
      @(posedge Clk);
      #1;
      in_sel   = sel;
      in_data  = d;
      in_valid = 1'b1;
      @(negedge Clk);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      if (exp_rdy) begin
         if (sel) qb.push_back(d);
         else     qa.push_back(d);
      end
   endtask

   task automatic idle();
      @(posedge Clk);
      #1;
      in_valid = 1'b0;
      @(negedge Clk);
   endtask

   initial begin
      Reset      = 1'b1;
      in_valid   = 1'b1;
      in_sel     = 1'b0;
      in_data    = 32'hDEADBEEF;
      outA_ready = 1'b1;
      outB_ready = 1'b1;
      na         = '0;
      nb         = '0;
      fork
         monitor_loop();
      join_none

      // Reset held three cycles with a word offered.
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_validA", {31'd0, outA_valid}, 32'd0);
      chk("rst_validB", {31'd0, outB_valid}, 32'd0);
      chk("rst_dataA", outA_data, 32'd0);
      chk("rst_dataB", outB_data, 32'd0);
      chk("rst_cntA", {24'd0, cntA}, 32'd0);
      chk("rst_cntB", {24'd0, cntB}, 32'd0);
      @(posedge Clk);
      #1;
      Reset    = 1'b0;
      in_valid = 1'b0;
      @(negedge Clk);
      chk("post_rst_validA", {31'd0, outA_valid}, 32'd0);

      // Basic steering to each side.
      offer(1'b0, 32'h00000001, 1'b1);
      offer(1'b1, 32'h00000002, 1'b1);
      idle();
      idle();
      chk("basic_cntA", {24'd0, cntA}, 32'd1);
      chk("basic_cntB", {24'd0, cntB}, 32'd1);

      // Back-pressure on A; B still accepts in the same cycle.
      outA_ready = 1'b0;
      offer(1'b0, 32'hF0000001, 1'b1);
      offer(1'b0, 32'hF0000002, 1'b0);
      chk("bp_holdA", outA_data, 32'hF0000001);
      in_sel  = 1'b1;
      in_data = 32'hB0000001;
      #1;
      chk("switch_in_ready", {31'd0, in_ready}, 32'd1);
      qb.push_back(32'hB0000001);

      // Simultaneous drain and load on a full slot.
      @(posedge Clk);
      #1;
      outA_ready = 1'b1;
      in_sel     = 1'b0;
      in_data    = 32'hF0000002;
      in_valid   = 1'b1;
      @(negedge Clk);
      chk("replace_in_ready", {31'd0, in_ready}, 32'd1);
      qa.push_back(32'hF0000002);
      idle();
      chk("replace_validA", {31'd0, outA_valid}, 32'd1);
      chk("replace_dataA", outA_data, 32'hF0000002);
      chk("replace_cntA", {24'd0, cntA}, 32'd2);
      chk("replace_cntB", {24'd0, cntB}, 32'd2);
      idle();
      chk("drain_cntA", {24'd0, cntA}, 32'd3);

      // Reset while both slots are full and stalled.
      outA_ready = 1'b0;
      outB_ready = 1'b0;
      offer(1'b0, 32'hA5A5A5A5, 1'b1);
      offer(1'b1, 32'h5A5A5A5A, 1'b1);
      idle();
      chk("full_validA", {31'd0, outA_valid}, 32'd1);
      chk("full_validB", {31'd0, outB_valid}, 32'd1);
      @(posedge Clk);
      #1;
      Reset    = 1'b1;
      in_valid = 1'b1;
      in_sel   = 1'b0;
      in_data  = 32'h12345678;
      @(negedge Clk);
      chk("rst2_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge Clk);
      chk("rst2_validA", {31'd0, outA_valid}, 32'd0);
      chk("rst2_validB", {31'd0, outB_valid}, 32'd0);
      chk("rst2_cntA", {24'd0, cntA}, 32'd0);
      chk("rst2_cntB", {24'd0, cntB}, 32'd0);
      @(posedge Clk);
      #1;
      Reset      = 1'b0;
      in_valid   = 1'b0;
      outA_ready = 1'b1;
      outB_ready = 1'b1;
      repeat (3) @(negedge Clk);
      chk("rst2_no_stale_A", {31'd0, outA_valid}, 32'd0);
      chk("rst2_no_stale_B", {31'd0, outB_valid}, 32'd0);

      // 256 A handshakes wrap the 8-bit counter.
      for (int i = 0; i < 256; i++) begin
         offer(1'b0, 32'(i) ^ 32'hC0DE0000, 1'b1);
      end
      idle();
      idle();
      chk("wrap_cntA", {24'd0, cntA}, 32'd0);
      chk("wrap_cntB", {24'd0, cntB}, 32'd0);
      chk("wrap_qA_empty", 32'(qa.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
